// File: rtl/alu_pkg.sv
// Shared types for the ALU / multiply-divide unit: opcode encoding and the
// control FSM states, plus a helper that classifies iterative opcodes.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SLL   = 4'd3,
    OP_ANDN  = 4'd4,
    OP_ORN   = 4'd5,
    OP_SUB   = 4'd6,
    OP_SLT   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULU  = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_NOP14 = 4'd14,
    OP_NOP15 = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  function automatic logic isMduOp(alu_op_e op);
    return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle of the ALU/MDU: valid/ready request side with
// operands, flush, and a valid/ready result side.
interface alu_mdu_if #(parameter int WIDTH = 32);

  logic             valid_i;
  logic             ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i, ready_i,
    input  ready_o, valid_o, result_o, hi_o, zero_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i, ready_i,
    output ready_o, valid_o, result_o, hi_o, zero_o
  );

endinterface

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// Operands become magnitudes at start; signs are restored on the final step.
module mdu_iter #(parameter int WIDTH = 32) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_div;
  logic               r_negMain;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   r_a;

  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_nextHi;
  logic [WIDTH-1:0]   w_nextLo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_aNeg = signed_i && a_i[WIDTH-1];
  assign w_bNeg = signed_i && b_i[WIDTH-1];
  assign w_aMag = w_aNeg ? -a_i : a_i;
  assign w_bMag = w_bNeg ? -b_i : b_i;
  assign done_o = r_busy && (r_count == CW'(WIDTH - 1));

  // Partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_mag});
    w_diff  = w_shift[WIDTH-1:0] - r_mag;
    if (r_div) begin
      w_nextHi = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_nextLo = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_nextHi = w_sum[WIDTH:1];
      w_nextLo = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_prod = {w_nextHi, w_nextLo};
    hi_o   = '0;
    lo_o   = '0;
    if (r_div) begin
      hi_o = r_negRem  ? -w_nextHi : w_nextHi;
      lo_o = r_negMain ? -w_nextLo : w_nextLo;
      if (r_divZero) begin
        hi_o = r_a;
        lo_o = '1;
      end
    end else begin
      {hi_o, lo_o} = r_negMain ? -w_prod : w_prod;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_div     <= 1'b0;
      r_negMain <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mag     <= '0;
      r_a       <= '0;
    end else if (clear_i) begin
      r_busy  <= 1'b0;
      r_count <= '0;
    end else if (start_i) begin
      r_busy    <= 1'b1;
      r_count   <= '0;
      r_div     <= div_i;
      r_negMain <= w_aNeg ^ w_bNeg;
      r_negRem  <= w_aNeg;
      r_divZero <= div_i && (b_i == '0);
      r_a       <= a_i;
      r_hi      <= '0;
      r_lo      <= div_i ? w_aMag : w_bMag;
      r_mag     <= div_i ? w_bMag : w_aMag;
    end else if (r_busy) begin
      r_hi    <= w_nextHi;
      r_lo    <= w_nextLo;
      r_count <= r_count + CW'(1);
      if (done_o) begin
        r_busy  <= 1'b0;
        r_count <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Handshaked ALU: single-cycle ops are computed here, multiply/divide run in
// mdu_iter; both land in the same registered result held until consumed.
module alu_mdu
  import alu_pkg::*;
#(parameter int WIDTH = 32) (
  input logic      clk_i,
  input logic      rst_i,
  alu_mdu_if.slave bus
);

  localparam int SW = $clog2(WIDTH);

  mdu_state_e       r_state;
  mdu_state_e       w_nextState;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_isMdu;
  logic             w_mduDone;
  logic [SW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_aluRes;
  logic [WIDTH-1:0] w_mduHi;
  logic [WIDTH-1:0] w_mduLo;

  assign w_op         = alu_op_e'(bus.op_i);
  assign w_isMdu      = isMduOp(w_op);
  assign w_shamt      = bus.a_i[SW-1:0];
  assign bus.ready_o  = ((r_state == IDLE) || ((r_state == DONE) && bus.ready_i)) && !bus.flush_i;
  assign w_accept     = bus.valid_i && bus.ready_o;
  assign bus.valid_o  = (r_state == DONE);
  assign bus.result_o = r_result;
  assign bus.hi_o     = r_hi;
  assign bus.zero_o   = r_zero;

  always_comb begin
    w_aluRes = '0;
    case (w_op)
      OP_AND:  w_aluRes = bus.a_i & bus.b_i;
      OP_OR:   w_aluRes = bus.a_i | bus.b_i;
      OP_ADD:  w_aluRes = bus.a_i + bus.b_i;
      OP_SLL:  w_aluRes = bus.b_i << w_shamt;
      OP_ANDN: w_aluRes = bus.a_i & ~bus.b_i;
      OP_ORN:  w_aluRes = bus.a_i | ~bus.b_i;
      OP_SUB:  w_aluRes = bus.a_i - bus.b_i;
      OP_SLT:  w_aluRes = {{(WIDTH-1){1'b0}}, ($signed(bus.a_i) < $signed(bus.b_i))};
      OP_SRL:  w_aluRes = bus.b_i >> w_shamt;
      OP_SRA:  w_aluRes = $signed(bus.b_i) >>> w_shamt;
      default: w_aluRes = '0;
    endcase
  end

  // Flush overrides everything; DONE can re-issue directly when the result is consumed.
  always_comb begin
    w_nextState = r_state;
    if (bus.flush_i) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: if (w_accept) w_nextState = w_isMdu ? BUSY : DONE;
        BUSY: if (w_mduDone) w_nextState = DONE;
        DONE: begin
          if (w_accept)         w_nextState = w_isMdu ? BUSY : DONE;
          else if (bus.ready_i) w_nextState = IDLE;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
    end else if (w_accept && !w_isMdu) begin
      r_result <= w_aluRes;
      r_hi     <= '0;
      r_zero   <= (w_aluRes == '0);
    end else if ((r_state == BUSY) && w_mduDone && !bus.flush_i) begin
      r_result <= w_mduLo;
      r_hi     <= w_mduHi;
      r_zero   <= (w_mduLo == '0);
    end
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_accept && w_isMdu),
    .clear_i  (bus.flush_i),
    .div_i    ((w_op == OP_DIV) || (w_op == OP_DIVU)),
    .signed_i ((w_op == OP_MUL) || (w_op == OP_DIV)),
    .a_i      (bus.a_i),
    .b_i      (bus.b_i),
    .done_o   (w_mduDone),
    .hi_o     (w_mduHi),
    .lo_o     (w_mduLo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: the driver queues hand-computed results and a
// negedge monitor checks latency, hold-while-stalled and values on handshake.
module tb_alu_mdu;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zero;
    int          expCyc;
  } exp_t;

  logic        clk_i;
  logic        rst_i;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          lastAccept = 0;
  int          riseCyc = 0;
  bit          presented = 0;
  logic [31:0] heldRes;
  logic [31:0] heldHi;
  exp_t        sbQ[$];

  alu_mdu_if #(.WIDTH(32)) bus();

  alu_mdu #(.WIDTH(32)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Holds valid_i until accepted, then scrambles operands so late changes would show.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input logic [31:0] expHi,
                               input int lat, input bit track);
    exp_t e;
    bit   got;
    int   budget;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.valid_i = 1'b1;
    got    = 0;
    budget = 0;
    while (!got && budget < 200) begin
      @(negedge clk_i);
      if (bus.ready_o) begin
        got        = 1;
        lastAccept = cyc;
      end
      @(posedge clk_i);
      budget++;
    end
    if (got && track) begin
      e.res    = expRes;
      e.hi     = expHi;
      e.zero   = (expRes == 32'd0);
      e.expCyc = lastAccept + lat;
      sbQ.push_back(e);
    end
    #1;
    bus.valid_i = 1'b0;
    bus.op_i    = 4'($urandom);
    bus.a_i     = $urandom;
    bus.b_i     = $urandom;
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: ready_o never high for op %0d, required acceptance", op);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        presented = 0;
      end else if (bus.valid_o) begin
        if (!presented) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: valid_o=1 result_o=0x%0h, required valid_o=0", bus.result_o);
          end else begin
            presented = 1;
            heldRes   = bus.result_o;
            heldHi    = bus.hi_o;
            checkOutput("latency", 64'(cyc), 64'(sbQ[0].expCyc));
          end
        end else begin
          checkOutput("hold_result", 64'(bus.result_o), 64'(heldRes));
          checkOutput("hold_hi", 64'(bus.hi_o), 64'(heldHi));
        end
        if (presented && bus.ready_i) begin
          checkOutput("result_o", 64'(bus.result_o), 64'(sbQ[0].res));
          checkOutput("hi_o", 64'(bus.hi_o), 64'(sbQ[0].hi));
          checkOutput("zero_o", 64'(bus.zero_o), 64'(sbQ[0].zero));
          void'(sbQ.pop_front());
          presented = 0;
        end
      end
    end
  end

  initial begin
    int budget;
    rst_i       = 1'b1;
    bus.valid_i = 1'b0;
    bus.op_i    = 4'd0;
    bus.a_i     = 32'd0;
    bus.b_i     = 32'd0;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_valid_o", 64'(bus.valid_o), 64'(0));
    checkOutput("rst_result_o", 64'(bus.result_o), 64'(0));
    checkOutput("rst_hi_o", 64'(bus.hi_o), 64'(0));
    checkOutput("rst_zero_o", 64'(bus.zero_o), 64'(1));
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rel_ready_o", 64'(bus.ready_o), 64'(1));
    @(posedge clk_i);
    #1;

    applyStimulus(4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1, 1);
    applyStimulus(4'd0,  32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 32'h0, 1, 1);
    applyStimulus(4'd1,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1, 1);
    applyStimulus(4'd3,  32'h00000004, 32'h00000001, 32'h00000010, 32'h0, 1, 1);
    applyStimulus(4'd3,  32'h00000024, 32'h0000000F, 32'h000000F0, 32'h0, 1, 1);
    applyStimulus(4'd4,  32'hFF00FF00, 32'h0F0F0F0F, 32'hF000F000, 32'h0, 1, 1);
    applyStimulus(4'd5,  32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1, 1);
    applyStimulus(4'd6,  32'h00000005, 32'h00000007, 32'hFFFFFFFE, 32'h0, 1, 1);
    applyStimulus(4'd7,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1, 1);
    applyStimulus(4'd7,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1, 1);
    applyStimulus(4'd8,  32'h00000004, 32'h80000000, 32'h08000000, 32'h0, 1, 1);
    applyStimulus(4'd14, 32'h00001234, 32'h00005678, 32'h00000000, 32'h0, 1, 1);
    applyStimulus(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0, 1, 1);
    applyStimulus(4'd10, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 33, 1);
    applyStimulus(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 33, 1);
    applyStimulus(4'd10, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 33, 1);
    applyStimulus(4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1);
    applyStimulus(4'd12, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 33, 1);
    applyStimulus(4'd13, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, 33, 1);
    applyStimulus(4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33, 1);
    applyStimulus(4'd12, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, 33, 1);

    // Stall the consumer on an SRA result, then release it together with a new request.
    applyStimulus(4'd9, 32'h00000004, 32'h80000000, 32'hF8000000, 32'h0, 1, 1);
    bus.ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      checkOutput("stall_ready_o", 64'(bus.ready_o), 64'(0));
      checkOutput("stall_valid_o", 64'(bus.valid_o), 64'(1));
    end
    @(posedge clk_i);
    #1;
    riseCyc     = cyc;
    bus.ready_i = 1'b1;
    applyStimulus(4'd5, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0, 1, 1);
    checkOutput("b2b_accept_cycle", 64'(lastAccept), 64'(riseCyc));

    // Flush a DIVU ten cycles in while a competing request is offered.
    applyStimulus(4'd13, 32'h00000064, 32'h00000007, 32'h0, 32'h0, 33, 0);
    repeat (9) @(posedge clk_i);
    #1;
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.op_i    = 4'd2;
    bus.a_i     = 32'h00000001;
    bus.b_i     = 32'h00000001;
    @(negedge clk_i);
    checkOutput("flush_ready_o", 64'(bus.ready_o), 64'(0));
    @(posedge clk_i);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("flush_idle_ready_o", 64'(bus.ready_o), 64'(1));
    checkOutput("flush_valid_o", 64'(bus.valid_o), 64'(0));
    repeat (40) @(posedge clk_i);
    #1;
    applyStimulus(4'd13, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 33, 1);

    // Reset in the middle of a multiply; result registers still hold the DIVU result.
    applyStimulus(4'd10, 32'h00000003, 32'h00000005, 32'h0, 32'h0, 33, 0);
    repeat (10) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_valid_o", 64'(bus.valid_o), 64'(0));
    checkOutput("midrst_result_o", 64'(bus.result_o), 64'(0));
    checkOutput("midrst_hi_o", 64'(bus.hi_o), 64'(0));
    checkOutput("midrst_zero_o", 64'(bus.zero_o), 64'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    checkOutput("postrst_ready_o", 64'(bus.ready_o), 64'(1));
    checkOutput("postrst_valid_o", 64'(bus.valid_o), 64'(0));
    repeat (40) @(posedge clk_i);
    #1;

    applyStimulus(4'd11, 32'h00000006, 32'h00000007, 32'h0000002A, 32'h00000000, 33, 1);
    applyStimulus(4'd2,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1, 1);

    budget = 0;
    while ((sbQ.size() != 0) && (budget < 100)) begin
      @(posedge clk_i);
      budget++;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", sbQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter: WIDTH, 32, datapath width (even, >=8).
REQ-002 SHALL have port: clk_i  input  1  single clock, rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: valid_i  input  1  request valid.
REQ-005 SHALL have port: ready_o  output  1  request accepted when valid_i && ready_o.
REQ-006 SHALL have port: op_i  input  4  operation code.
REQ-007 SHALL have port: a_i, b_i  input  WIDTH  operands.
REQ-008 SHALL have port: flush_i  input  1  synchronous cancel of any in-flight operation.
REQ-009 SHALL have port: valid_o  output  1  result valid.
REQ-010 SHALL have port: ready_i  input  1  result consumed when valid_o && ready_i.
REQ-011 SHALL have port: result_o  output  WIDTH  result, or low half for mul/div.
REQ-012 SHALL have port: hi_o  output  WIDTH  high half for mul, remainder for div, otherwise 0.
REQ-013 SHALL have port: zero_o  output  1  result_o == 0.

Function
REQ-014 Op codes 0-9 SHALL be: AND, OR, ADD, SLL (b<<a), ANDN (a&~b), ORN (a|~b), SUB, SLT (signed), SRL (b>>a), SRA (b>>>a).
REQ-015 Op codes 10-13 SHALL be: MUL (signed), MULU, DIV (signed), DIVU; codes 14-15 SHALL give result_o=0, hi_o=0 with single-cycle timing.
REQ-016 Shift amount SHALL be a_i[$clog2(WIDTH)-1:0]; upper bits ignored.
REQ-017 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-018 FSM states SHALL be IDLE, BUSY, DONE.
REQ-019 IDLE: on accept of op 0-9/14-15 -> DONE next cycle (latency 1); on accept of op 10-13 -> BUSY.
REQ-020 BUSY: iterate one bit per cycle for exactly WIDTH cycles, then -> DONE (latency WIDTH+1 from accept).
REQ-021 DONE: valid_o=1; result_o, hi_o, zero_o SHALL be registered and stable until ready_i.
REQ-022 ready_o SHALL be (IDLE || (DONE && ready_i)) && !flush_i; accept in DONE with ready_i gives back-to-back issue.
REQ-023 DONE && ready_i without new accept -> IDLE.
REQ-024 flush_i in any state -> IDLE next cycle, valid_o=0, no request accepted that cycle; flush wins over valid_i and ready_i.
REQ-025 Operands and op SHALL be captured at accept; a_i/b_i/op_i changes afterward SHALL NOT affect the result.
REQ-026 MUL/MULU: {hi_o,result_o} = full 2*WIDTH-bit product.
REQ-027 DIV/DIVU: result_o = quotient truncated toward zero, hi_o = remainder with sign of dividend.
REQ-028 Divide by zero: result_o = all ones, hi_o = a; SHALL still take WIDTH+1 cycles.
REQ-029 Signed DIV of MIN by -1: result_o = MIN, hi_o = 0.
REQ-030 ready_o SHALL be 0 throughout BUSY.

Reset
REQ-031 rst_i SHALL asynchronously force IDLE; valid_o=0, result_o=0, hi_o=0, zero_o=1, iteration counter=0.
REQ-032 Reset mid-BUSY SHALL discard the operation; no result presented after release.
REQ-033 ready_o SHALL be 1 in the first cycle after reset release (when flush_i=0).

Structure
REQ-034 Shared package alu_pkg SHALL hold the alu_op_e enum (codes 0-15) and the mdu_state_e enum.
REQ-035 Iterative shift-add multiplier and restoring divider SHALL be one sub-module, mdu_iter (start, operands, signed flag, done, hi/lo); the single-cycle ops SHALL remain in alu_mdu.
REQ-036 Sign correction SHALL be applied in mdu_iter before and after iteration; the counter SHALL be $clog2(WIDTH)+1 bits.

Verification (WIDTH=32)
REQ-037 ADD a=0xFFFFFFFF b=1, ready_i=1 -> valid_o one cycle after accept, result_o=0, zero_o=1, hi_o=0.
REQ-038 MUL a=-3 b=7 -> valid_o 33 cycles after accept, result_o=0xFFFFFFEB, hi_o=0xFFFFFFFF; MULU 0xFFFFFFFF*0xFFFFFFFF -> hi_o=0xFFFFFFFE, result_o=1.
REQ-039 DIV a=-7 b=2 -> result_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIVU a=5 b=0 -> result_o=0xFFFFFFFF, hi_o=5; DIV 0x80000000 by -1 -> result_o=0x80000000, hi_o=0.
REQ-040 SRA a=4 b=0x80000000 with ready_i=0 for 5 cycles -> result_o=0xF8000000 held stable with valid_o=1 and ready_o=0 until ready_i; new op accepted the same cycle ready_i rises.
REQ-041 flush_i asserted 10 cycles into DIVU together with valid_i -> IDLE next cycle, valid_o never asserts, that request not accepted, next request completes correctly.
REQ-042 rst_i asserted mid-MUL -> outputs at reset values immediately; after release ready_o=1, no stale valid_o.
